// File: rtl/cond_exec_em_stage.sv
// ---------------------------------------------------------------------------
// cond_exec_em_stage
//   Execute-stage condition unit and Execute->Memory pipeline register.
//   Owns the architectural NZCV flags register. It evaluates CondE against
//   that register and squashes the control writes of instructions that fail
//   their condition. It updates the flags from the ALU and registers the E
//   results into M (1-cycle latency). FlagsOut feeds the D/E register.
//
//   Optional feature macro: COND_STATS_EN
//     When defined, the module adds saturating ExecCnt / SquashCnt counters
//     (CNT_W bits each).
//
// Ports
//   CLK, RST            clock, synchronous active-high reset
//   ValidE              instruction in E is real (0 = bubble)
//   PCSrcE .. FlagWriteE  E control requests
//   CondE               ARM condition field
//   ALUFlags            {N,Z,C,V} from the ALU this cycle
//   ALUResultE, WriteDataE, WA3E   E data
//   StallM, FlushM      hold / squash the E/M register
//   CondExE             condition passed (combinational)
//   BranchTakenE        redirect to fetch (combinational)
//   FlagsOut            NZCV register
//   ValidM .. WA3M      registered M-stage outputs
//   ExecCnt, SquashCnt  statistics (COND_STATS_EN only)
// ---------------------------------------------------------------------------
module cond_exec_em_stage #(
    parameter int SIZE  = 32,
    parameter int CNT_W = 16
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            ValidE,
    input  logic            PCSrcE,
    input  logic            RegWriteE,
    input  logic            MemToRegE,
    input  logic            MemWriteE,
    input  logic            BranchE,
    input  logic            FlagWriteE,
    input  logic [3:0]      CondE,
    input  logic [3:0]      ALUFlags,
    input  logic [SIZE-1:0] ALUResultE,
    input  logic [SIZE-1:0] WriteDataE,
    input  logic [3:0]      WA3E,
    input  logic            StallM,
    input  logic            FlushM,
    output logic            CondExE,
    output logic            BranchTakenE,
    output logic [3:0]      FlagsOut,
    output logic            ValidM,
    output logic            PCSrcM,
    output logic            RegWriteM,
    output logic            MemToRegM,
    output logic            MemWriteM,
    output logic [SIZE-1:0] ALUResultM,
    output logic [SIZE-1:0] WriteDataM,
    output logic [3:0]      WA3M
`ifdef COND_STATS_EN
    ,
    output logic [CNT_W-1:0] ExecCnt,
    output logic [CNT_W-1:0] SquashCnt
`endif
);

    logic flag_n, flag_z, flag_c, flag_v;
    logic exec_ok;   // condition passed on a real instruction
    logic load;      // E/M register captures this edge

    assign {flag_n, flag_z, flag_c, flag_v} = FlagsOut;

    always_comb begin
        CondExE = 1'b0;
        unique case (CondE)
            4'h0: CondExE = flag_z;
            4'h1: CondExE = !flag_z;
            4'h2: CondExE = flag_c;
            4'h3: CondExE = !flag_c;
            4'h4: CondExE = flag_n;
            4'h5: CondExE = !flag_n;
            4'h6: CondExE = flag_v;
            4'h7: CondExE = !flag_v;
            4'h8: CondExE = flag_c && !flag_z;
            4'h9: CondExE = !flag_c || flag_z;
            4'hA: CondExE = (flag_n == flag_v);
            4'hB: CondExE = (flag_n != flag_v);
            4'hC: CondExE = !flag_z && (flag_n == flag_v);
            4'hD: CondExE = flag_z || (flag_n != flag_v);
            4'hE: CondExE = 1'b1;
            4'hF: CondExE = 1'b0;
            default: CondExE = 1'b0;
        endcase
    end

    assign exec_ok      = CondExE && ValidE;
    assign BranchTakenE = (BranchE || PCSrcE) && exec_ok;

    // Flush outranks stall, so a stalled+flushed edge is not a load edge.
    assign load = !StallM && !FlushM;

    // Flags register: only written by an executing instruction that will
    // actually advance into M, so a stalled or flushed op cannot commit flags.
    always_ff @(posedge CLK) begin
        if (RST)
            FlagsOut <= 4'b0000;
        else if (load && exec_ok && FlagWriteE)
            FlagsOut <= ALUFlags;
    end

    // E/M register. Data and WA3 are captured even for failed instructions;
    // only the side-effecting controls are gated by the condition.
    always_ff @(posedge CLK) begin
        if (RST || FlushM) begin
            ValidM     <= 1'b0;
            PCSrcM     <= 1'b0;
            RegWriteM  <= 1'b0;
            MemToRegM  <= 1'b0;
            MemWriteM  <= 1'b0;
            ALUResultM <= '0;
            WriteDataM <= '0;
            WA3M       <= '0;
        end else if (!StallM) begin
            ValidM     <= ValidE;
            PCSrcM     <= PCSrcE    && exec_ok;
            RegWriteM  <= RegWriteE && exec_ok;
            MemToRegM  <= MemToRegE && exec_ok;
            MemWriteM  <= MemWriteE && exec_ok;
            ALUResultM <= ALUResultE;
            WriteDataM <= WriteDataE;
            WA3M       <= WA3E;
        end
    end

`ifdef COND_STATS_EN
    // Saturating counters of executed vs squashed real instructions.
    always_ff @(posedge CLK) begin
        if (RST) begin
            ExecCnt   <= '0;
            SquashCnt <= '0;
        end else if (load && ValidE) begin
            if (CondExE) begin
                if (ExecCnt != '1)
                    ExecCnt <= ExecCnt + 1'b1;
            end else begin
                if (SquashCnt != '1)
                    SquashCnt <= SquashCnt + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_cond_exec_em_stage.sv
module tb_cond_exec_em_stage;

    localparam int SIZE  = 32;
    localparam int CNT_W = 4;

    logic            CLK = 1'b0;
    logic            RST;
    logic            ValidE, PCSrcE, RegWriteE, MemToRegE, MemWriteE, BranchE, FlagWriteE;
    logic [3:0]      CondE, ALUFlags, WA3E;
    logic [SIZE-1:0] ALUResultE, WriteDataE;
    logic            StallM, FlushM;
    logic            CondExE, BranchTakenE;
    logic [3:0]      FlagsOut, WA3M;
    logic            ValidM, PCSrcM, RegWriteM, MemToRegM, MemWriteM;
    logic [SIZE-1:0] ALUResultM, WriteDataM;
`ifdef COND_STATS_EN
    logic [CNT_W-1:0] ExecCnt, SquashCnt;
`endif

    cond_exec_em_stage #(.SIZE(SIZE), .CNT_W(CNT_W)) dut (
        .CLK(CLK), .RST(RST), .ValidE(ValidE), .PCSrcE(PCSrcE), .RegWriteE(RegWriteE),
        .MemToRegE(MemToRegE), .MemWriteE(MemWriteE), .BranchE(BranchE),
        .FlagWriteE(FlagWriteE), .CondE(CondE), .ALUFlags(ALUFlags),
        .ALUResultE(ALUResultE), .WriteDataE(WriteDataE), .WA3E(WA3E),
        .StallM(StallM), .FlushM(FlushM), .CondExE(CondExE), .BranchTakenE(BranchTakenE),
        .FlagsOut(FlagsOut), .ValidM(ValidM), .PCSrcM(PCSrcM), .RegWriteM(RegWriteM),
        .MemToRegM(MemToRegM), .MemWriteM(MemWriteM), .ALUResultM(ALUResultM),
        .WriteDataM(WriteDataM), .WA3M(WA3M)
`ifdef COND_STATS_EN
        , .ExecCnt(ExecCnt), .SquashCnt(SquashCnt)
`endif
    );

    always #5 CLK = ~CLK;

    int total = 0;
    int bad   = 0;
    bit started = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    // Even condition codes test a base predicate; odd codes are its inverse.
    function automatic bit cond_pass(input logic [3:0] c, input logic [3:0] f);
        bit n, z, cy, v, base;
        {n, z, cy, v} = f;
        case (c[3:1])
            3'd0: base = z;
            3'd1: base = cy;
            3'd2: base = n;
            3'd3: base = v;
            3'd4: base = cy & ~z;
            3'd5: base = (n == v);
            3'd6: base = ~z & (n == v);
            default: base = 1'b1;
        endcase
        return base ^ c[0];
    endfunction

    logic [3:0]      m_flags;
    logic [4:0]      m_ctl;      // {valid, pcsrc, regwrite, memtoreg, memwrite}
    logic [SIZE-1:0] m_alu, m_wd;
    logic [3:0]      m_wa3;
    int              m_exec, m_sq;

    always @(posedge CLK) begin
        bit pass;
        pass = cond_pass(CondE, m_flags) && ValidE;
        if (RST) begin
            m_flags = 0; m_ctl = 0; m_alu = 0; m_wd = 0; m_wa3 = 0; m_exec = 0; m_sq = 0;
            started = 1;
        end else if (FlushM) begin
            m_ctl = 0; m_alu = 0; m_wd = 0; m_wa3 = 0;
        end else if (!StallM) begin
            m_ctl = {ValidE, PCSrcE & pass, RegWriteE & pass, MemToRegE & pass, MemWriteE & pass};
            m_alu = ALUResultE; m_wd = WriteDataE; m_wa3 = WA3E;
            if (pass && FlagWriteE) m_flags = ALUFlags;
            if (ValidE) begin
                if (pass) m_exec = (m_exec < (1 << CNT_W) - 1) ? m_exec + 1 : m_exec;
                else      m_sq   = (m_sq   < (1 << CNT_W) - 1) ? m_sq + 1   : m_sq;
            end
        end
    end

    // Single compare process: every cycle, away from the active edge.
    always @(negedge CLK) begin
        if (started) begin
            bit cx;
            cx = cond_pass(CondE, m_flags);
            chk("CondExE", CondExE, cx);
            chk("BranchTakenE", BranchTakenE, (BranchE | PCSrcE) & cx & ValidE);
            chk("FlagsOut", FlagsOut, m_flags);
            chk("ctlM", {ValidM, PCSrcM, RegWriteM, MemToRegM, MemWriteM}, m_ctl);
            chk("ALUResultM", ALUResultM, m_alu);
            chk("WriteDataM", WriteDataM, m_wd);
            chk("WA3M", WA3M, m_wa3);
`ifdef COND_STATS_EN
            chk("ExecCnt", ExecCnt, m_exec[CNT_W-1:0]);
            chk("SquashCnt", SquashCnt, m_sq[CNT_W-1:0]);
`endif
        end
    end

    // ---------------- stimulus ----------------
    task automatic idle();
        ValidE = 0; PCSrcE = 0; RegWriteE = 0; MemToRegE = 0; MemWriteE = 0; BranchE = 0;
        FlagWriteE = 0; CondE = 4'hE; ALUFlags = 0; ALUResultE = 0; WriteDataE = 0;
        WA3E = 0; StallM = 0; FlushM = 0; RST = 0;
    endtask

    task automatic tick();
        @(posedge CLK); #1;
    endtask

    task automatic set_flags(input logic [3:0] f);
        idle(); ValidE = 1; CondE = 4'hE; FlagWriteE = 1; ALUFlags = f;
        tick();
    endtask

    initial begin
        idle(); RST = 1;
        tick();
        // reset state (literal pins)
        chk("rst FlagsOut", FlagsOut, 4'b0000);
        chk("rst ValidM", ValidM, 1'b0);
        chk("rst ALUResultM", ALUResultM, 32'h0);
        chk("rst RegWriteM", RegWriteM, 1'b0);

        set_flags(4'b0100);
        chk("flags load", FlagsOut, 4'b0100);

        idle(); ValidE = 1; CondE = 4'h0; RegWriteE = 1; tick();
        chk("EQ RegWriteM", RegWriteM, 1'b1);
        idle(); ValidE = 1; CondE = 4'h1; RegWriteE = 1; tick();
        chk("NE RegWriteM", RegWriteM, 1'b0);

        set_flags(4'b1001);
        idle(); ValidE = 1; CondE = 4'hA; #1;
        chk("GE N=V", CondExE, 1'b1);
        set_flags(4'b1000);
        idle(); ValidE = 1; CondE = 4'hB; #1;
        chk("LT N!=V", CondExE, 1'b1);
        CondE = 4'hA; #1;
        chk("GE N!=V", CondExE, 1'b0);

        // squashed store with flag write
        idle(); ValidE = 1; CondE = 4'h0; MemWriteE = 1; FlagWriteE = 1; ALUFlags = 4'b1111;
        ALUResultE = 32'h1234; tick();
        chk("squash MemWriteM", MemWriteM, 1'b0);
        chk("squash FlagsOut", FlagsOut, 4'b1000);
        chk("squash ALUResultM", ALUResultM, 32'h1234);
        chk("squash ValidM", ValidM, 1'b1);

        // two stall cycles with fresh E inputs
        for (int i = 0; i < 2; i++) begin
            idle(); StallM = 1; ValidE = 1; CondE = 4'hE; RegWriteE = 1; FlagWriteE = 1;
            ALUFlags = 4'b0011; ALUResultE = $urandom; WA3E = 4'h7; tick();
            chk("stall ALUResultM", ALUResultM, 32'h1234);
            chk("stall FlagsOut", FlagsOut, 4'b1000);
            chk("stall RegWriteM", RegWriteM, 1'b0);
        end

        idle(); StallM = 1; FlushM = 1; ValidE = 1; CondE = 4'hE; FlagWriteE = 1;
        ALUFlags = 4'b0001; ALUResultE = 32'hDEAD; tick();
        chk("stall+flush ValidM", ValidM, 1'b0);
        chk("stall+flush ALUResultM", ALUResultM, 32'h0);
        chk("stall+flush FlagsOut", FlagsOut, 4'b1000);

        // randomized phase
        for (int i = 0; i < 400; i++) begin
            ValidE = $urandom_range(0, 3) != 0;
            {PCSrcE, RegWriteE, MemToRegE, MemWriteE, BranchE, FlagWriteE} = 6'($urandom);
            CondE = 4'($urandom); ALUFlags = 4'($urandom);
            ALUResultE = $urandom; WriteDataE = $urandom; WA3E = 4'($urandom);
            StallM = $urandom_range(0, 6) == 0;
            FlushM = $urandom_range(0, 9) == 0;
            RST    = $urandom_range(0, 40) == 0;
            tick();
        end

        // saturation / counter scenario (model covers it every cycle when enabled)
        idle(); RST = 1; tick();
        for (int i = 0; i < 20; i++) begin
            idle(); ValidE = 1; CondE = 4'hE; tick();
        end
        for (int i = 0; i < 3; i++) begin
            idle(); ValidE = 1; CondE = 4'hF; tick();
        end
        for (int i = 0; i < 4; i++) begin
            idle(); ValidE = 0; CondE = 4'hE; tick();
        end
`ifdef COND_STATS_EN
        chk("ExecCnt sat", ExecCnt, 4'hF);
        chk("SquashCnt", SquashCnt, 4'd3);
`endif
        chk("final ValidM", ValidM, 1'b0);

        idle(); tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
